// File: rtl/jumps_pkg.sv
// rtl/jumps_pkg.sv - path_t codes, per-code control words and the terminating-lane predicate.
package jumps_pkg;

    typedef enum logic [2:0] {
        PATH_CONTINUE0   = 3'd0,
        PATH_BREAK0      = 3'd1,
        PATH_RETURN0     = 3'd2,
        PATH_CONTINUE1   = 3'd3,
        PATH_BREAK1      = 3'd4,
        PATH_RETURN1     = 3'd5,
        PATH_FALLTHROUGH = 3'd6,
        PATH_INIT        = 3'd7
    } path_t;

    localparam logic [5:0] WORD_CONTINUE0   = 6'b000001;
    localparam logic [5:0] WORD_BREAK0      = 6'b000010;
    localparam logic [5:0] WORD_RETURN0     = 6'b000100;
    localparam logic [5:0] WORD_CONTINUE1   = 6'b001000;
    localparam logic [5:0] WORD_BREAK1      = 6'b010000;
    localparam logic [5:0] WORD_RETURN1     = 6'b100000;
    localparam logic [5:0] WORD_FALLTHROUGH = 6'b000000;
    localparam logic [5:0] WORD_INIT        = 6'b000000;

    function automatic logic is_term(path_t p);
        return (p == PATH_BREAK0) || (p == PATH_RETURN0) ||
               (p == PATH_BREAK1) || (p == PATH_RETURN1);
    endfunction

endpackage

// File: rtl/jump_path_lane_enc.sv
// rtl/jump_path_lane_enc.sv - combinational encoder for a single lane's path code.
module jump_path_lane_enc
    import jumps_pkg::*;
(
    input  path_t      path_i,
    output logic [5:0] word_o,
    output logic       is_term_o,
    output logic       is_init_o
);

    always_comb begin
        word_o = WORD_FALLTHROUGH;
        case (path_i)
            PATH_CONTINUE0:   word_o = WORD_CONTINUE0;
            PATH_BREAK0:      word_o = WORD_BREAK0;
            PATH_RETURN0:     word_o = WORD_RETURN0;
            PATH_CONTINUE1:   word_o = WORD_CONTINUE1;
            PATH_BREAK1:      word_o = WORD_BREAK1;
            PATH_RETURN1:     word_o = WORD_RETURN1;
            PATH_FALLTHROUGH: word_o = WORD_FALLTHROUGH;
            PATH_INIT:        word_o = WORD_INIT;
            default:          word_o = WORD_FALLTHROUGH;
        endcase
    end

    assign is_term_o = is_term(path_i);
    assign is_init_o = (path_i == PATH_INIT);

endmodule

// File: rtl/jump_path_encoder.sv
// rtl/jump_path_encoder.sv - walks a path group one lane per cycle and builds per-lane control words.
// Optional JUMP_PATH_ENCODER_TERM_EN adds out_term / out_term_lane.
module jump_path_encoder
    import jumps_pkg::*;
#(
    parameter  int NLANES = 8,
    localparam int LIDX_W = $clog2(NLANES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3*NLANES-1:0]   in_paths,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [6*NLANES-1:0]   out_words,
    output logic                  out_err
`ifdef JUMP_PATH_ENCODER_TERM_EN
    ,
    output logic                  out_term,
    output logic [LIDX_W-1:0]     out_term_lane
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WALK = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(NLANES - 1);

    logic [1:0]           state_q, state_d;
    logic [3*NLANES-1:0]  paths_q, paths_d;
    logic [6*NLANES-1:0]  words_q, words_d;
    logic                 err_q, err_d;
    logic [LIDX_W-1:0]    lane_q, lane_d;
`ifdef JUMP_PATH_ENCODER_TERM_EN
    logic                 term_q, term_d;
    logic [LIDX_W-1:0]    term_lane_q, term_lane_d;
`endif

    path_t       cur_path;
    logic [5:0]  lane_word;
    logic        lane_is_term;
    logic        lane_is_init;

    // Lane 0 sits in the MSBs, so lane i is counted down from the top.
    always_comb begin
        cur_path = PATH_FALLTHROUGH;
        for (int i = 0; i < NLANES; i++) begin
            if (lane_q == LIDX_W'(i)) begin
                cur_path = path_t'(paths_q[3*(NLANES-1-i) +: 3]);
            end
        end
    end

    jump_path_lane_enc u_lane_enc (
        .path_i    (cur_path),
        .word_o    (lane_word),
        .is_term_o (lane_is_term),
        .is_init_o (lane_is_init)
    );

    always_comb begin
        state_d = state_q;
        paths_d = paths_q;
        words_d = words_q;
        err_d   = err_q;
        lane_d  = lane_q;
`ifdef JUMP_PATH_ENCODER_TERM_EN
        term_d      = term_q;
        term_lane_d = term_lane_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    paths_d = in_paths;
                    words_d = '0;
                    err_d   = 1'b0;
                    lane_d  = '0;
                    state_d = ST_WALK;
`ifdef JUMP_PATH_ENCODER_TERM_EN
                    term_d      = 1'b0;
                    term_lane_d = '0;
`endif
                end
            end
            ST_WALK: begin
                for (int i = 0; i < NLANES; i++) begin
                    if (lane_q == LIDX_W'(i)) begin
                        words_d[6*(NLANES-1-i) +: 6] = lane_word;
                    end
                end
                if (lane_is_init) begin
                    err_d = 1'b1;
                end
                // Words were cleared at capture, so stopping here leaves dead lanes at zero.
                if (lane_is_term || (lane_q == LAST_LANE)) begin
                    state_d = ST_DONE;
`ifdef JUMP_PATH_ENCODER_TERM_EN
                    term_d      = lane_is_term;
                    term_lane_d = lane_q;
`endif
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            paths_q <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
            lane_q  <= '0;
`ifdef JUMP_PATH_ENCODER_TERM_EN
            term_q      <= 1'b0;
            term_lane_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            paths_q <= paths_d;
            words_q <= words_d;
            err_q   <= err_d;
            lane_q  <= lane_d;
`ifdef JUMP_PATH_ENCODER_TERM_EN
            term_q      <= term_d;
            term_lane_q <= term_lane_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_words = words_q;
    assign out_err   = err_q;
`ifdef JUMP_PATH_ENCODER_TERM_EN
    assign out_term      = term_q;
    assign out_term_lane = term_lane_q;
`endif

endmodule
